// File: rtl/pdm_tx_pkg.sv
// Shared constants for the PDM transmit modulator: register map, STATUS layout,
// sigma-delta feedback levels and the OSR floor.
package pdm_tx_pkg;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_OSR    = 4'd1;
    localparam logic [3:0] REG_DATA   = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;

    localparam int ST_EMPTY    = 4;
    localparam int ST_FULL     = 5;
    localparam int ST_UNDERRUN = 6;
    localparam int ST_OVERFLOW = 7;

    localparam logic signed [16:0] FB_POS = 17'sd32767;
    localparam logic signed [16:0] FB_NEG = -17'sd32768;

    localparam logic [7:0] OSR_MIN = 8'd4;

    function automatic logic [7:0] clamp_osr(input logic [7:0] v);
        return (v < OSR_MIN) ? OSR_MIN : v;
    endfunction

endpackage

// File: rtl/pdm_tx_fifo.sv
// Sample FIFO between the register port and the modulator; push and pop may
// coincide, including a push into a full FIFO that is being popped.
module pdm_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (do_pop && !do_push) level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wp] <= din;
    end

endmodule

// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: register slave, mclk tick detect, OSR sample fetch and a
// saturating second-order sigma-delta loop driving a 1-bit pad.
module pdm_tx_modulator
    import pdm_tx_pkg::*;
#(
    parameter int OSR_RST    = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int INT1_W     = 20,
    parameter int INT2_W     = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_valid_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    input  logic        wbs_strb_i,
    output logic        wbs_ack_o,
    output logic [15:0] wbs_dat_o,
    output logic        hi_z_o,
    input  logic        mclk_i,
    output logic        pdm_o,
    output logic        pdm_oeb_o,
    output logic        irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int S1 = INT1_W + 2;
    localparam int S2 = INT2_W + 2;
    localparam logic signed [S1-1:0] I1_MAX = {3'b000, {(INT1_W-1){1'b1}}};
    localparam logic signed [S1-1:0] I1_MIN = {3'b111, {(INT1_W-1){1'b0}}};
    localparam logic signed [S2-1:0] I2_MAX = {3'b000, {(INT2_W-1){1'b1}}};
    localparam logic signed [S2-1:0] I2_MIN = {3'b111, {(INT2_W-1){1'b0}}};

    logic               en, mclk_q, y, underrun, overflow;
    logic [7:0]         osr, cnt;
    logic signed [15:0] x, x_cur, head;
    logic signed [16:0] fb;
    logic signed [INT1_W-1:0] i1, i1_new;
    logic signed [INT2_W-1:0] i2, i2_new;
    logic signed [S1-1:0] s1;
    logic signed [S2-1:0] s2;
    logic [LW-1:0]      level;
    logic               full, empty, tick, wr, clr, push, fetch, pop;
    logic [15:0]        status, rdata;

    assign tick  = mclk_i & ~mclk_q;
    assign wr    = wb_valid_i & wbs_strb_i;
    assign clr   = wr && (wbs_adr_i == REG_CTRL) && wbs_dat_i[1];
    assign push  = wr && (wbs_adr_i == REG_DATA);
    assign fetch = en && tick && (cnt == 8'd0) && !clr;
    assign pop   = fetch && !empty;

    pdm_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .clr(clr), .push(push), .pop(pop),
        .din(wbs_dat_i), .dout(head), .level(level), .full(full), .empty(empty)
    );

    // Sums are formed two bits wider than the integrators so saturation can see overshoot.
    always_comb begin
        fb    = y ? FB_POS : FB_NEG;
        x_cur = x;
        if (fetch) x_cur = empty ? 16'sd0 : head;
        s1 = S1'(i1) + S1'(x_cur) - S1'(fb);
        if (s1 > I1_MAX)      i1_new = I1_MAX[INT1_W-1:0];
        else if (s1 < I1_MIN) i1_new = I1_MIN[INT1_W-1:0];
        else                  i1_new = s1[INT1_W-1:0];
        s2 = S2'(i2) + S2'(i1_new) - S2'(fb);
        if (s2 > I2_MAX)      i2_new = I2_MAX[INT2_W-1:0];
        else if (s2 < I2_MIN) i2_new = I2_MIN[INT2_W-1:0];
        else                  i2_new = s2[INT2_W-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mclk_q <= 1'b0;
            i1     <= '0;
            i2     <= '0;
            y      <= 1'b0;
            cnt    <= '0;
            x      <= '0;
        end else begin
            mclk_q <= mclk_i;
            if (clr || !en) begin
                i1  <= '0;
                i2  <= '0;
                y   <= 1'b0;
                cnt <= '0;
                if (clr) x <= '0;
            end else if (tick) begin
                i1  <= i1_new;
                i2  <= i2_new;
                y   <= ~i2_new[INT2_W-1];
                x   <= x_cur;
                cnt <= (cnt == 8'd0) ? osr - 8'd1 : cnt - 8'd1;
            end
        end
    end

    always_comb begin
        status              = 16'(level);
        status[ST_EMPTY]    = empty;
        status[ST_FULL]     = full;
        status[ST_UNDERRUN] = underrun;
        status[ST_OVERFLOW] = overflow;
        case (wbs_adr_i)
            REG_CTRL:   rdata = {15'd0, en};
            REG_OSR:    rdata = {8'd0, osr};
            REG_STATUS: rdata = status;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en        <= 1'b0;
            osr       <= 8'(OSR_RST);
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_valid_i;
            wbs_dat_o <= (wb_valid_i && !wbs_strb_i) ? rdata : '0;
            if (wr && wbs_adr_i == REG_CTRL) en  <= wbs_dat_i[0];
            if (wr && wbs_adr_i == REG_OSR)  osr <= clamp_osr(wbs_dat_i[7:0]);
            // A fresh event in the same cycle as a write-1-to-clear keeps the flag set.
            if (fetch && empty)
                underrun <= 1'b1;
            else if (wr && wbs_adr_i == REG_STATUS && wbs_dat_i[ST_UNDERRUN])
                underrun <= 1'b0;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (wr && wbs_adr_i == REG_STATUS && wbs_dat_i[ST_OVERFLOW])
                overflow <= 1'b0;
        end
    end

    assign hi_z_o    = ~wbs_ack_o;
    assign pdm_o     = y & en;
    assign pdm_oeb_o = ~en;
    assign irq_o     = underrun | overflow;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// Directed bench for pdm_tx_modulator: register access, FIFO boundaries, and the
// modulator bitstream checked against hand-derived sequences and density bounds.
module tb_pdm_tx_modulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  adr = '0;
    logic [15:0] dat = '0;
    logic        strb = 1'b0;
    logic        ack, hi_z, pdm, oeb, irq;
    logic [15:0] rdat;
    logic        mclk = 1'b0;

    int checks = 0;
    int errors = 0;

    pdm_tx_modulator dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_valid_i(valid), .wbs_adr_i(adr),
        .wbs_dat_i(dat), .wbs_strb_i(strb), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .hi_z_o(hi_z), .mclk_i(mclk), .pdm_o(pdm), .pdm_oeb_o(oeb), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic [3:0] a, input logic [15:0] d, input logic s,
                       output logic [15:0] r, output logic k);
        @(negedge clk);
        valid = 1'b1; adr = a; dat = d; strb = s;
        @(negedge clk);
        valid = 1'b0; strb = 1'b0; dat = '0;
        r = rdat; k = ack;
    endtask

    task automatic tick(output logic b);
        @(negedge clk); mclk = 1'b1;
        @(negedge clk); mclk = 1'b0;
        b = pdm;
    endtask

    task automatic test_reset();
        logic [15:0] r; logic k;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
        checks++; if (hi_z !== 1'b1) begin errors++; $display("FAIL reset_hi_z got %b want 1", hi_z); end
        checks++; if ({pdm, oeb, irq} !== 3'b010) begin errors++; $display("FAIL reset_pads got pdm/oeb/irq=%b want 010", {pdm, oeb, irq}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (k !== 1'b1 || hi_z !== 1'b0) begin errors++; $display("FAIL reset_read_ack got ack=%b hi_z=%b want 1/0", k, hi_z); end
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL reset_status got %h want 0010", r); end
        bus(4'd1, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'd64) begin errors++; $display("FAIL reset_osr got %0d want 64", r); end
        bus(4'd9, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0 || k !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h ack=%b want 0000 ack=1", r, k); end
        @(negedge clk);
        checks++; if (ack !== 1'b0 || hi_z !== 1'b1 || rdat !== 16'h0) begin errors++; $display("FAIL ack_one_cycle got ack=%b hi_z=%b dat=%h want 0/1/0000", ack, hi_z, rdat); end
    endtask

    task automatic test_overflow();
        logic [15:0] r; logic k;
        for (int i = 0; i < 9; i++) bus(4'd2, 16'(i * 3), 1'b1, r, k);
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h00A8) begin errors++; $display("FAIL overflow_status got %h want 00a8", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL overflow_irq got %b want 1", irq); end
        bus(4'd3, 16'h0080, 1'b1, r, k);
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0028) begin errors++; $display("FAIL overflow_clear got %h want 0028", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL overflow_irq_clear got %b want 0", irq); end
        bus(4'd0, 16'h0002, 1'b1, r, k);
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL clr_flush got %h want 0010", r); end
    endtask

    task automatic test_zero_input();
        logic [15:0] r; logic k; logic b;
        logic [5:0] first = '0;
        int ones = 0, run = 0, max_run = 0;
        logic prev = 1'b0;
        bus(4'd1, 16'd4, 1'b1, r, k);
        for (int i = 0; i < 8; i++) bus(4'd2, 16'h0000, 1'b1, r, k);
        bus(4'd0, 16'h0001, 1'b1, r, k);
        checks++; if (oeb !== 1'b0 || pdm !== 1'b0) begin errors++; $display("FAIL zero_enable got oeb=%b pdm=%b want 0/0", oeb, pdm); end
        for (int t = 0; t < 32; t++) begin
            tick(b);
            if (t < 6) first[5-t] = b;
            ones += int'(b);
            run = (t > 0 && b == prev) ? run + 1 : 1;
            if (run > max_run) max_run = run;
            prev = b;
        end
        checks++; if (first !== 6'b110100) begin errors++; $display("FAIL zero_first_bits got %b want 110100", first); end
        checks++; if (ones < 14 || ones > 18) begin errors++; $display("FAIL zero_density got %0d want 16+-2", ones); end
        checks++; if (max_run > 2) begin errors++; $display("FAIL zero_run got %0d want <=2", max_run); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL zero_drained got %h want 0010", r); end
        bus(4'd0, 16'h0000, 1'b1, r, k);
        checks++; if (oeb !== 1'b1 || pdm !== 1'b0) begin errors++; $display("FAIL disable_pads got oeb=%b pdm=%b want 1/0", oeb, pdm); end
    endtask

    task automatic test_underrun();
        logic [15:0] r; logic k; logic b;
        logic [4:0] rest = '0;
        bus(4'd0, 16'h0001, 1'b1, r, k);
        tick(b);
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL underrun_bit0 got %b want 1", b); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0050) begin errors++; $display("FAIL underrun_status got %h want 0050", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL underrun_irq got %b want 1", irq); end
        for (int t = 0; t < 5; t++) begin tick(b); rest[4-t] = b; end
        checks++; if (rest !== 5'b10100) begin errors++; $display("FAIL underrun_bits got %b want 10100", rest); end
        bus(4'd0, 16'h0000, 1'b1, r, k);
        bus(4'd3, 16'h0040, 1'b1, r, k);
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0010 || irq !== 1'b0) begin errors++; $display("FAIL underrun_clear got %h irq=%b want 0010 irq=0", r, irq); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic k;
        for (int i = 0; i < 8; i++) bus(4'd2, 16'h0000, 1'b1, r, k);
        bus(4'd0, 16'h0001, 1'b1, r, k);
        // Fetch tick and DATA push on the same edge while full.
        @(negedge clk);
        mclk = 1'b1; valid = 1'b1; adr = 4'd2; dat = 16'h1234; strb = 1'b1;
        @(negedge clk);
        mclk = 1'b0; valid = 1'b0; strb = 1'b0;
        checks++; if (pdm !== 1'b1) begin errors++; $display("FAIL b2b_pdm got %b want 1", pdm); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0028) begin errors++; $display("FAIL b2b_status got %h want 0028", r); end
        bus(4'd0, 16'h0002, 1'b1, r, k);
    endtask

    task automatic test_osr_clr();
        logic [15:0] r; logic k; logic b;
        logic [3:0] seq = '0;
        bus(4'd1, 16'd2, 1'b1, r, k);
        bus(4'd1, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'd4) begin errors++; $display("FAIL osr_clamp2 got %0d want 4", r); end
        bus(4'd1, 16'd0, 1'b1, r, k);
        bus(4'd1, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'd4) begin errors++; $display("FAIL osr_clamp0 got %0d want 4", r); end
        bus(4'd1, 16'd5, 1'b1, r, k);
        bus(4'd1, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'd5) begin errors++; $display("FAIL osr_five got %0d want 5", r); end
        bus(4'd1, 16'd4, 1'b1, r, k);
        for (int i = 0; i < 3; i++) bus(4'd2, 16'h4000, 1'b1, r, k);
        bus(4'd0, 16'h0001, 1'b1, r, k);
        for (int t = 0; t < 3; t++) tick(b);
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL stream_level got %h want 0002", r); end
        bus(4'd0, 16'h0003, 1'b1, r, k);
        checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL clr_pdm got %b want 0", pdm); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL clr_level got %h want 0010", r); end
        for (int t = 0; t < 4; t++) begin tick(b); seq[3-t] = b; end
        checks++; if (seq !== 4'b1101) begin errors++; $display("FAIL clr_restart got %b want 1101", seq); end
        bus(4'd0, 16'h0000, 1'b1, r, k);
        bus(4'd3, 16'h00C0, 1'b1, r, k);
        bus(4'd0, 16'h0002, 1'b1, r, k);
    endtask

    task automatic test_full_scale();
        logic [15:0] r; logic k; logic b;
        int ones = 0;
        bus(4'd1, 16'd16, 1'b1, r, k);
        for (int i = 0; i < 8; i++) bus(4'd2, 16'h7000, 1'b1, r, k);
        bus(4'd0, 16'h0001, 1'b1, r, k);
        for (int t = 0; t < 256; t++) begin
            tick(b);
            ones += int'(b);
            if (t % 16 == 15) bus(4'd2, 16'h7000, 1'b1, r, k);
        end
        checks++; if (ones < 233 || ones > 247) begin errors++; $display("FAIL fullscale_density got %0d want 233..247", ones); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if ((r & 16'h00D0) !== 16'h0000) begin errors++; $display("FAIL fullscale_flags got %h want no empty/underrun/overflow", r); end
    endtask

    task automatic test_async_reset();
        logic [15:0] r; logic k; logic b;
        bus(4'd3, 16'h0, 1'b0, r, k);
        @(negedge clk); valid = 1'b1; adr = 4'd3; strb = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        valid = 1'b0;
        checks++; if ({ack, hi_z, pdm, oeb, irq} !== 5'b01010) begin errors++; $display("FAIL async_reset got ack/hi_z/pdm/oeb/irq=%b want 01010", {ack, hi_z, pdm, oeb, irq}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus(4'd1, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'd64) begin errors++; $display("FAIL async_osr got %0d want 64", r); end
        bus(4'd3, 16'h0, 1'b0, r, k);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL async_status got %h want 0010", r); end
        tick(b);
        checks++; if (b !== 1'b0 || oeb !== 1'b1) begin errors++; $display("FAIL async_disabled got pdm=%b oeb=%b want 0/1", b, oeb); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_zero_input();
        test_underrun();
        test_back_to_back();
        test_osr_clr();
        test_full_scale();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/pdm_tx_modulator.md
# pdm_tx_modulator

Transmit-side counterpart of the microphone PDM receive path: converts 16-bit PCM samples written over the register slave port into a 1-bit PDM bitstream clocked by the shared microphone clock `mclk`. A second-order sigma-delta loop drives an IO pad. The pad feeds a transducer driver, or loops back into a SonarOnChip `pdm_data_i` input for self-test. The block sits beside the SonarOnChip instances in `top`, on the same decoded 16-bit register bus.

## Interface
- `OSR_RST`, 64: oversampling ratio after reset (mclk edges per PCM sample).
- `FIFO_DEPTH`, 8: sample FIFO depth, power of two.
- `INT1_W`, 20: integrator 1 width.
- `INT2_W`, 24: integrator 2 width.
- `wb_clk_i` in 1: system clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `wb_valid_i` in 1: decoded select for this block; 1-cycle pulse.
- `wbs_adr_i` in 4: register index.
- `wbs_dat_i` in 16: write data.
- `wbs_strb_i` in 1: 1 = write, 0 = read.
- `wbs_ack_o` out 1: 1-cycle acknowledge.
- `wbs_dat_o` out 16: read data, valid with ack, else 0.
- `hi_z_o` out 1: high whenever `wbs_ack_o` is low.
- `mclk_i` in 1: microphone clock level, synchronous to `wb_clk_i`.
- `pdm_o` out 1: PDM bitstream.
- `pdm_oeb_o` out 1: pad output-enable bar; 0 while enabled.
- `irq_o` out 1: OR of the sticky error flags.

## Operation
- Registers:
  - 0 CTRL: bit0 EN; bit1 CLR, self-clearing (flush FIFO, zero integrators and OSR counter).
  - 1 OSR[7:0]: writes below 4 store 4.
  - 2 DATA: a write pushes a signed sample; reads return 0.
  - 3 STATUS: [3:0] level; bit4 empty; bit5 full; bit6 UNDERRUN; bit7 OVERFLOW. Writing 1 clears bit6/bit7.
  - Other addresses: reads return 0, writes are ignored, ack is still given.
- Edge detect: `mclk_q` is registered. Tick = `mclk_i & ~mclk_q`. All modulator state advances only on ticks.
- OSR counter `cnt`: on a tick with `cnt==0`, load `x` from the FIFO head (pop) and reload `cnt = OSR-1`; otherwise decrement. The loaded `x` is used in the same tick's loop update.
- Empty at fetch: `x` = 0 and UNDERRUN is set.
- Loop per tick, with `fb = y ? +32767 : -32768` from the previous `y`:
  - `i1 += x - fb`
  - `i2 += i1 - fb`
  - `y = (i2_new >= 0)`
  - Both integrators saturate at their signed limits; they never wrap.
- EN=0: integrators, `cnt` and `y` are held at 0; `pdm_o` = 0; `pdm_oeb_o` = 1; FIFO contents are retained.
- EN 0→1: the first tick fetches a sample (`cnt` = 0).
- Push while full: sample dropped; OVERFLOW is set.
  - Push and pop in the same cycle while full: both happen, level unchanged.
  - Pop on empty with a simultaneous push: underrun is taken and the pushed sample lands.
- CLR and a tick in the same cycle: CLR wins.

## Timing
- Reset values:
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0, `hi_z_o` = 1.
  - `pdm_o` = 0, `pdm_oeb_o` = 1, `irq_o` = 0.
  - OSR = `OSR_RST`, EN = 0, FIFO empty, flags 0.
- Register access: `wbs_ack_o` is high exactly one cycle after `wb_valid_i`, with read data on `wbs_dat_o` in that cycle.
  - A write takes effect on the `wb_valid_i` edge; a read in the next access reflects it.
- `pdm_o` updates on the `wb_clk_i` edge following the tick cycle and is stable for a full mclk period.
- STATUS flags and `irq_o` assert one cycle after the causing event.
- Reset assertion mid-stream forces all reset values immediately (asynchronous); release is synchronous to `wb_clk_i`.

## Structure
- Package `pdm_tx_pkg` holds:
  - register indices (CTRL, OSR, DATA, STATUS);
  - STATUS bit positions;
  - feedback constants ±32767/-32768;
  - the OSR minimum of 4.
- Sub-module `pdm_tx_fifo`: synchronous FIFO with push/pop/level/full/empty, simultaneous push+pop supported.
- Top level holds the register file, tick detect, OSR counter and the sigma-delta loop.

## Test plan
- **Reset:** release reset, read STATUS → 0x0010 (empty); read OSR → 64; `pdm_oeb_o` = 1; `pdm_o` = 0.
- **Zero input:** push 8×0x0000, EN=1, OSR=4, mclk/2 → density of ones over 32 ticks is 16 ± 2, no run longer than 2.
- **Near full scale:** push 0x7000 repeatedly (keep FIFO non-empty), OSR=16 → density over 256 ticks within ±3% of 93.75%; integrators never wrap.
- **Overflow:** push 9 samples with EN=0 → STATUS = 0x00A8 (level 8, full, OVERFLOW), `irq_o` = 1; write 0x0080 to STATUS → bit7 clears, `irq_o` = 0.
- **Underrun:** EN=1 with empty FIFO → UNDERRUN set after the first tick; `pdm_o` toggles as for zero input.
- **OSR clamp and CLR:** write OSR=2 → reads 4; CLR while streaming → level 0, `pdm_o` restarts from the zero state.
